// File: rtl/iecdrv_sd_arbiter.sv
// iecdrv_sd_arbiter: round-robin merge of per-drive sector request channels
// onto the single host SD block interface. One drive is granted at a time.
// The granted drive's LBA and command are latched for the whole transfer,
// and the ack and write-data byte are routed back to and from that drive.
module iecdrv_sd_arbiter #(
  parameter int unsigned NDR      = 2,
  parameter int unsigned TMO_BITS = 24
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [32*NDR-1:0] drv_lba,
  input  logic [NDR-1:0]    drv_rd,
  input  logic [NDR-1:0]    drv_wr,
  output logic [NDR-1:0]    drv_ack,
  input  logic [8*NDR-1:0]  drv_buff_din,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic              sd_ack,
  output logic [7:0]        sd_buff_din,
  output logic              busy,
  output logic [1:0]        cur_drive,
  output logic              timeout
);

  localparam int unsigned SW = (NDR > 1) ? $clog2(NDR) : 1;
  localparam int unsigned WW = (TMO_BITS > 0) ? TMO_BITS : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [SW-1:0] LAST_INIT = SW'(NDR - 1);
  localparam logic [WW-1:0] WD_MAX    = '1;
  localparam logic [WW-1:0] WD_LAST   = WD_MAX - 1'b1;

  logic [1:0]    r_state;
  logic [SW-1:0] r_sel;
  logic [SW-1:0] r_last;
  logic [WW-1:0] r_wdog;
  logic [31:0]   r_lba;
  logic          r_rd;
  logic          r_wr;
  logic          r_timeout;

  logic [NDR-1:0] w_pending;
  logic           w_any;
  logic [SW-1:0]  w_pick;
  int unsigned    w_idx;
  logic           w_active;
  logic           w_wd_hit;

  assign w_pending = drv_rd | drv_wr;
  assign w_active  = (r_state == S_REQ) || (r_state == S_XFER);
  // Saturation is detected one count early so the abort edge is the
  // (2^TMO_BITS-1)-th REQ cycle without ack.
  assign w_wd_hit  = (TMO_BITS > 0) && (r_wdog == WD_LAST);

  // Round-robin search: first pending drive starting just after the last grant
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = 0;
    for (int unsigned k = 1; k <= NDR; k++) begin
      w_idx = (int'(r_last) + k) % NDR;
      if (!w_any && w_pending[w_idx]) begin
        w_any  = 1'b1;
        w_pick = SW'(w_idx);
      end
    end
  end

  // Request FSM: grant, wait for host ack or watchdog, transfer, release
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_last    <= LAST_INIT;
      r_wdog    <= '0;
      r_lba     <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel   <= w_pick;
            r_lba   <= drv_lba[w_pick*32 +: 32];
            r_wr    <= drv_wr[w_pick];
            r_rd    <= drv_rd[w_pick] & ~drv_wr[w_pick];
            r_wdog  <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (sd_ack) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_state <= S_XFER;
          end else if (w_wd_hit) begin
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_XFER: begin
          if (!sd_ack) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_last  <= r_sel;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Ack routing is combinational so the first transferred byte reaches the drive
  always_comb begin
    drv_ack = '0;
    for (int unsigned i = 0; i < NDR; i++) begin
      drv_ack[i] = sd_ack & w_active & (r_sel == SW'(i));
    end
  end

  assign sd_buff_din = drv_buff_din[r_sel*8 +: 8];
  assign sd_lba      = r_lba;
  assign sd_rd       = r_rd;
  assign sd_wr       = r_wr;
  assign busy        = (r_state != S_IDLE);
  assign cur_drive   = 2'(r_sel);
  assign timeout     = r_timeout;

endmodule
